// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - symbolic-instruction input and encoded-word output bundle
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_mnem;
    logic [4:0]  in_dest;
    logic [4:0]  in_src1;
    logic [4:0]  in_src2;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        illegal;
    logic [7:0]  err_cnt;

    // Producer of symbolic instructions and consumer of encoded words
    modport master (
        output in_valid, in_mnem, in_dest, in_src1, in_src2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, illegal, err_cnt
    );

    // The encoder itself
    modport slave (
        input  in_valid, in_mnem, in_dest, in_src1, in_src2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, illegal, err_cnt
    );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - symbolic instruction to 32-bit word encoder with FIFO and branch NOP padding
module instr_encoder #(
    parameter int DEPTH   = 4,
    parameter int BR_NOPS = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    instr_encoder_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_ACCEPT,
        ST_PAD
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [1:0]     pad_cnt_q;
    logic [1:0]     pad_cnt_d;

    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic [31:0]    mem_q [DEPTH];

    logic           full;
    logic           empty;
    logic           accept;
    logic           push;
    logic           pop;
    logic [31:0]    push_word;

    logic [5:0]     opcode;
    logic           r_type;
    logic           legal;
    logic           is_branch;
    logic [31:0]    enc_word;

    logic           illegal_q;
    logic [7:0]     err_cnt_q;

    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = !empty && bus.out_ready;

    assign bus.in_ready  = rst_n && (state_q == ST_ACCEPT) && !full;
    assign bus.out_valid = !empty;
    assign bus.out_instr = mem_q[rd_ptr_q];
    assign bus.illegal   = illegal_q;
    assign bus.err_cnt   = err_cnt_q;

    // Mnemonic lookup: opcode, field layout and legality
    always_comb begin
        opcode    = 6'b000000;
        r_type    = 1'b1;
        legal     = 1'b1;
        is_branch = 1'b0;
        case (bus.in_mnem)
            5'd0:  opcode = 6'b000000;
            5'd1:  opcode = 6'b000001;
            5'd2:  opcode = 6'b000011;
            5'd3:  opcode = 6'b000101;
            5'd4:  opcode = 6'b000110;
            5'd5:  opcode = 6'b000111;
            5'd6:  opcode = 6'b001000;
            5'd7:  opcode = 6'b001001;
            5'd8:  opcode = 6'b001010;
            5'd9:  opcode = 6'b001011;
            5'd10: opcode = 6'b001100;
            5'd11: begin
                opcode = 6'b100000;
                r_type = 1'b0;
            end
            5'd12: begin
                opcode = 6'b100001;
                r_type = 1'b0;
            end
            5'd13: begin
                opcode = 6'b100100;
                r_type = 1'b0;
            end
            5'd14: begin
                opcode = 6'b100101;
                r_type = 1'b0;
            end
            5'd15: begin
                opcode    = 6'b101000;
                r_type    = 1'b0;
                is_branch = 1'b1;
            end
            5'd16: begin
                opcode    = 6'b101001;
                r_type    = 1'b0;
                is_branch = 1'b1;
            end
            5'd17: begin
                opcode    = 6'b101010;
                r_type    = 1'b0;
                is_branch = 1'b1;
            end
            5'd18: opcode = 6'b111111;
            default: legal = 1'b0;
        endcase
    end

    // Word assembly; NOP carries no operands so the whole word is zero
    always_comb begin
        enc_word = 32'h0000_0000;
        if (bus.in_mnem != 5'd0) begin
            if (r_type) begin
                enc_word = {opcode, bus.in_dest, bus.in_src1, bus.in_src2, 11'b0};
            end else begin
                enc_word = {opcode, bus.in_dest, bus.in_src1, bus.in_imm};
            end
        end
    end

    // FSM state and pad counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ACCEPT;
            pad_cnt_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            pad_cnt_q <= pad_cnt_d;
        end
    end

    // Next state and FIFO push source: encoded input in ACCEPT, NOP padding in PAD
    always_comb begin
        state_d   = state_q;
        pad_cnt_d = pad_cnt_q;
        push      = 1'b0;
        push_word = enc_word;
        case (state_q)
            ST_ACCEPT: begin
                if (accept && legal) begin
                    push = 1'b1;
                    if (is_branch && (BR_NOPS > 0)) begin
                        state_d   = ST_PAD;
                        pad_cnt_d = 2'(BR_NOPS);
                    end
                end
            end
            ST_PAD: begin
                if (!full) begin
                    push      = 1'b1;
                    push_word = 32'h0000_0000;
                    pad_cnt_d = pad_cnt_q - 2'd1;
                    if (pad_cnt_q == 2'd1) begin
                        state_d = ST_ACCEPT;
                    end
                end
            end
            default: begin
                state_d   = ST_ACCEPT;
                pad_cnt_d = 2'd0;
            end
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are don't-care after reset so no reset here
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    // Illegal-mnemonic pulse and saturating error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            illegal_q <= accept && !legal;
            if (accept && !legal && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - model-checked directed bench for instr_encoder
module tb_instr_encoder;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_n_s;
    logic [1:0]  in_valid_s;
    logic [1:0]  out_ready_s;
    logic [4:0]  mnem_s [2];
    logic [4:0]  dest_s [2];
    logic [4:0]  src1_s [2];
    logic [4:0]  src2_s [2];
    logic [15:0] imm_s  [2];

    logic [1:0]  rdy_w;
    logic [1:0]  oval_w;
    logic [1:0]  ill_w;
    logic [7:0]  err_w  [2];
    logic [31:0] instr_w [2];

    int s_pass = 0;
    int s_tot  = 0;

    // Reference encoding from the mnemonic table and field layout
    function automatic logic [31:0] enc(input logic [4:0] m, input logic [4:0] d,
                                        input logic [4:0] s1, input logic [4:0] s2,
                                        input logic [15:0] imm);
        logic [5:0] op;
        case (m)
            5'd1: op = 6'd1;   5'd2: op = 6'd3;   5'd3: op = 6'd5;   5'd4: op = 6'd6;
            5'd5: op = 6'd7;   5'd6: op = 6'd8;   5'd7: op = 6'd9;   5'd8: op = 6'd10;
            5'd9: op = 6'd11;  5'd10: op = 6'd12; 5'd11: op = 6'd32; 5'd12: op = 6'd33;
            5'd13: op = 6'd36; 5'd14: op = 6'd37; 5'd15: op = 6'd40; 5'd16: op = 6'd41;
            5'd17: op = 6'd42; 5'd18: op = 6'd63;
            default: op = 6'd0;
        endcase
        if (m == 5'd0) return 32'h0;
        if (m >= 5'd11 && m <= 5'd17) return (32'(op) << 26) | (32'(d) << 21) | (32'(s1) << 16) | 32'(imm);
        return (32'(op) << 26) | (32'(d) << 21) | (32'(s1) << 16) | (32'(s2) << 11);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int BRN = (g == 0) ? 2 : 3;

        instr_encoder_if bus ();

        instr_encoder #(.DEPTH(DEPTH), .BR_NOPS(BRN)) dut (
            .clk   (clk),
            .rst_n (rst_n_s[g]),
            .bus   (bus)
        );

        assign bus.in_valid  = in_valid_s[g];
        assign bus.in_mnem   = mnem_s[g];
        assign bus.in_dest   = dest_s[g];
        assign bus.in_src1   = src1_s[g];
        assign bus.in_src2   = src2_s[g];
        assign bus.in_imm    = imm_s[g];
        assign bus.out_ready = out_ready_s[g];
        assign rdy_w[g]      = bus.in_ready;
        assign oval_w[g]     = bus.out_valid;
        assign ill_w[g]      = bus.illegal;
        assign err_w[g]      = bus.err_cnt;
        assign instr_w[g]    = bus.out_instr;

        int          pass_c = 0;
        int          tot_c  = 0;
        logic [31:0] exp_q [$];
        logic [31:0] popped [$];
        int          pending = 0;
        bit          exp_ill = 1'b0;
        int          exp_err = 0;

        task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
            tot_c++;
            if (act === exp) pass_c++;
            else $display("FAIL inst%0d %s: got %h expected %h at %0t", g, nm, act, exp, $time);
        endtask

        // Compare DUT against the model, then advance the model over the coming edge
        always @(negedge clk) begin
            int occ;
            bit exp_rdy;
            occ     = exp_q.size() - pending;
            exp_rdy = rst_n_s[g] && (pending == 0) && (occ < DEPTH);
            if (!rst_n_s[g]) begin
                chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
                chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
                chk("rst_illegal", 32'(bus.illegal), 32'd0);
                chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
                exp_q.delete();
                pending = 0;
                exp_ill = 1'b0;
                exp_err = 0;
            end else begin
                chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
                chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
                chk("illegal", 32'(bus.illegal), 32'(exp_ill));
                chk("err_cnt", 32'(bus.err_cnt), 32'(exp_err));
                if (exp_q.size() > 0) chk("out_instr", bus.out_instr, exp_q[0]);
                exp_ill = 1'b0;
                if (pending > 0 && occ < DEPTH) pending--;
                if (exp_q.size() > 0 && out_ready_s[g]) begin
                    popped.push_back(bus.out_instr);
                    void'(exp_q.pop_front());
                end
                if (in_valid_s[g] && exp_rdy) begin
                    if (mnem_s[g] > 5'd18) begin
                        exp_ill = 1'b1;
                        if (exp_err < 255) exp_err++;
                    end else begin
                        exp_q.push_back(enc(mnem_s[g], dest_s[g], src1_s[g], src2_s[g], imm_s[g]));
                        if (mnem_s[g] >= 5'd15 && mnem_s[g] <= 5'd17) begin
                            for (int k = 0; k < BRN; k++) exp_q.push_back(32'h0);
                            pending = BRN;
                        end
                    end
                end
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        s_tot++;
        if (act === exp) s_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Present one instruction and hold it until accepted; returns the stall cycles seen
    task automatic send(input int g, input logic [4:0] m, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [15:0] imm, output int waits);
        bit acc;
        waits = 0;
        mnem_s[g] = m; dest_s[g] = d; src1_s[g] = s1; src2_s[g] = s2; imm_s[g] = imm;
        in_valid_s[g] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = rdy_w[g];
            @(posedge clk);
            #1;
            if (acc) begin
                in_valid_s[g] = 1'b0;
                return;
            end
            waits++;
        end
        in_valid_s[g] = 1'b0;
        lit("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        rst_n_s = 2'b00; in_valid_s = 2'b00; out_ready_s = 2'b11;
        for (int i = 0; i < 2; i++) begin
            mnem_s[i] = '0; dest_s[i] = '0; src1_s[i] = '0; src2_s[i] = '0; imm_s[i] = '0;
        end
        cycles(3);
        @(negedge clk);
        lit("reset_in_ready", 32'(rdy_w[0]), 32'd0);
        lit("reset_out_valid", 32'(oval_w[0]), 32'd0);
        @(posedge clk); #1;
        rst_n_s = 2'b11;
        cycles(1);

        // Test 1: single ADD, one-cycle latency, then empty
        send(0, 5'd1, 5'd3, 5'd1, 5'd2, 16'h0, w);
        @(negedge clk);
        lit("t1_out_valid", 32'(oval_w[0]), 32'd1);
        lit("t1_out_instr", instr_w[0], 32'h04611000);
        @(negedge clk);
        lit("t1_empty_after", 32'(oval_w[0]), 32'd0);
        cycles(1);

        // Test 2: ADDI then SWP in order
        send(0, 5'd11, 5'd4, 5'd5, 5'd0, 16'h0010, w);
        send(0, 5'd18, 5'd1, 5'd2, 5'd0, 16'h0, w);
        cycles(4);
        lit("t2_word0", inst[0].popped[1], 32'h80850010);
        lit("t2_word1", inst[0].popped[2], 32'hFC220000);

        // Test 3: BEZ followed by two pad NOPs, then ADD
        send(0, 5'd15, 5'd0, 5'd7, 5'd0, 16'hFFFE, w);
        send(0, 5'd1, 5'd3, 5'd1, 5'd2, 16'h0, w);
        lit("t3_stall_cycles", 32'(w), 32'd2);
        cycles(4);
        lit("t3_branch", inst[0].popped[3], 32'hA007FFFE);
        lit("t3_pad0", inst[0].popped[4], 32'h0);
        lit("t3_pad1", inst[0].popped[5], 32'h0);
        lit("t3_add", inst[0].popped[6], 32'h04611000);

        // Test 4: fill the FIFO, fifth word held until one pop
        out_ready_s[0] = 1'b0;
        send(0, 5'd2, 5'd1, 5'd2, 5'd3, 16'h0, w);
        send(0, 5'd3, 5'd4, 5'd5, 5'd6, 16'h0, w);
        send(0, 5'd4, 5'd7, 5'd8, 5'd9, 16'h0, w);
        send(0, 5'd6, 5'd10, 5'd11, 5'd12, 16'h0, w);
        mnem_s[0] = 5'd5; dest_s[0] = 5'd31; src1_s[0] = 5'd31; src2_s[0] = 5'd31;
        in_valid_s[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            lit("t4_full_hold", 32'(rdy_w[0]), 32'd0);
            @(posedge clk); #1;
        end
        out_ready_s[0] = 1'b1;
        @(negedge clk);
        lit("t4_full_during_pop", 32'(rdy_w[0]), 32'd0);
        @(posedge clk); #1;
        out_ready_s[0] = 1'b0;
        @(negedge clk);
        lit("t4_ready_after_pop", 32'(rdy_w[0]), 32'd1);
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
        out_ready_s[0] = 1'b1;
        cycles(8);
        lit("t4_w0", inst[0].popped[7], 32'h0C221800);
        lit("t4_w1", inst[0].popped[8], 32'h14853000);
        lit("t4_w2", inst[0].popped[9], 32'h18E84800);
        lit("t4_w3", inst[0].popped[10], 32'h214B6000);
        lit("t4_w4", inst[0].popped[11], 32'h1FFFF800);

        // Test 5: illegal mnemonic pulse and saturating count
        send(0, 5'd25, 5'd1, 5'd1, 5'd1, 16'h0, w);
        @(negedge clk);
        lit("t5_illegal_pulse", 32'(ill_w[0]), 32'd1);
        lit("t5_err_one", 32'(err_w[0]), 32'd1);
        lit("t5_no_push", 32'(oval_w[0]), 32'd0);
        @(negedge clk);
        lit("t5_illegal_drop", 32'(ill_w[0]), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 260; k++) send(0, 5'(19 + (k % 13)), 5'd0, 5'd0, 5'd0, 16'h0, w);
        cycles(2);
        lit("t5_err_saturated", 32'(err_w[0]), 32'd255);

        // Test 6: reset mid-PAD on the BR_NOPS=3 instance
        send(1, 5'd31, 5'd0, 5'd0, 5'd0, 16'h0, w);
        out_ready_s[1] = 1'b0;
        send(1, 5'd1, 5'd3, 5'd1, 5'd2, 16'h0, w);
        send(1, 5'd17, 5'd0, 5'd0, 5'd0, 16'h1234, w);
        cycles(1);
        @(negedge clk);
        lit("t6_err_before", 32'(err_w[1]), 32'd1);
        lit("t6_in_pad", 32'(rdy_w[1]), 32'd0);
        @(posedge clk); #1;
        rst_n_s[1] = 1'b0;
        @(negedge clk);
        lit("t6_rst_out_valid", 32'(oval_w[1]), 32'd0);
        lit("t6_rst_err", 32'(err_w[1]), 32'd0);
        cycles(2);
        rst_n_s[1] = 1'b1;
        @(negedge clk);
        lit("t6_accept_state", 32'(rdy_w[1]), 32'd1);
        out_ready_s[1] = 1'b1;
        @(posedge clk); #1;
        send(1, 5'd4, 5'd7, 5'd8, 5'd9, 16'h0, w);
        cycles(6);
        lit("t6_single_word_count", 32'(inst[1].popped.size()), 32'd1);
        if (inst[1].popped.size() > 0) lit("t6_single_word", inst[1].popped[0], 32'h18E84800);
        lit("t6_empty", 32'(oval_w[1]), 32'd0);

        s_pass = s_pass + inst[0].pass_c + inst[1].pass_c;
        s_tot  = s_tot + inst[0].tot_c + inst[1].tot_c;
        $display("%0d/%0d checks passed", s_pass, s_tot);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Assembles symbolic instructions into 32-bit instruction words for the instruction memory loader and the testbench program generator. It is the encode side of the control-unit opcode decode. Words are buffered in a small FIFO with valid/ready handshakes on both sides. After every branch or jump it can insert NOP delay-slot padding automatically.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
BR_NOPS, 0, NOP words inserted after each BEZ/BNE/JMP; range 0..3

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  symbolic instruction present
in_ready  out  1  encoder accepts this cycle
in_mnem  in  5  mnemonic: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOR, 6 XOR, 7 SLA, 8 SLL, 9 SRA, 10 SRL, 11 ADDI, 12 SUBI, 13 LD, 14 ST, 15 BEZ, 16 BNE, 17 JMP, 18 SWP; 19..31 illegal
in_dest  in  5  destination register / store-data register
in_src1  in  5  source 1 register
in_src2  in  5  source 2 register (R-type only)
in_imm  in  16  immediate (I-type only)
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer takes head
out_instr  out  32  FIFO head word
illegal  out  1  one-cycle pulse, illegal mnemonic was accepted
err_cnt  out  8  illegal-mnemonic count, saturates at 255

Behaviour:
- Reset (rst_n low, asynchronous): FIFO pointers and count go to 0. out_valid=0, illegal=0, err_cnt=0, state=ACCEPT. in_ready is forced 0 while rst_n is low. FIFO storage contents are don't-care.
- Word format: [31:26] opcode, [25:21] dest, [20:16] src1.
  - R-type (NOP..SRL, SWP): [15:11] src2, [10:0] zero.
  - I-type (ADDI..JMP): [15:0] imm.
- Opcodes by mnemonic:
  - NOP 000000, ADD 000001, SUB 000011, AND 000101, OR 000110, NOR 000111
  - XOR 001000, SLA 001001, SLL 001010, SRA 001011, SRL 001100
  - ADDI 100000, SUBI 100001, LD 100100, ST 100101
  - BEZ 101000, BNE 101001, JMP 101010, SWP 111111
- NOP word is always 0x00000000; operand fields are zeroed for NOP.
- Handshake:
  - An input transfer occurs on a clock edge with in_valid && in_ready.
  - in_ready = (state==ACCEPT) && !full.
  - Inputs must be held stable while in_valid=1 and in_ready=0.
- Latency: an accepted legal word is written into the FIFO at that edge. If the FIFO was empty, out_valid rises the next cycle with the word on out_instr. There is no combinational bypass.
- Output side:
  - out_valid = !empty; out_instr = head entry.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are allowed when not full or not empty respectively; count is unchanged.
  - A push while full never occurs, because in_ready=0 when full. Full is not relaxed by a same-cycle pop.
- Illegal mnemonic (19..31):
  - The handshake completes and nothing is pushed.
  - illegal pulses high for exactly one cycle after the accepting edge.
  - err_cnt increments and saturates at 255.
- State machine:
  - ACCEPT: on acceptance of BEZ/BNE/JMP with BR_NOPS>0, go to PAD with pad_cnt=BR_NOPS.
  - PAD: in_ready=0. Each cycle the FIFO is not full, push a NOP and decrement pad_cnt. When pad_cnt reaches 0 after the last push, go to ACCEPT; the next input can be accepted the following cycle.
  - With BR_NOPS=0, PAD is never entered.
- Ordering: words leave in exact acceptance order; padding NOPs immediately follow their branch.
- Reset during PAD or with a non-empty FIFO: all pending words and padding are discarded, and the encoder returns to ACCEPT with an empty FIFO.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits; full when count==DEPTH, empty when count==0.

Test Plan:
1. Reset, then ADD dest=3 src1=1 src2=2 with out_ready=1 -> out_instr=0x04611000 with out_valid high one cycle after acceptance; then empty.
2. ADDI dest=4 src1=5 imm=0x0010, then SWP dest=1 src1=2 src2=0 -> words 0x80850010 then 0xFC220000, in order.
3. BR_NOPS=2: BEZ src1=7 imm=0xFFFE, then ADD, in_valid held -> 0xA007FFFE, 0x00000000, 0x00000000, then the ADD word. in_ready is low for exactly 2 cycles after the BEZ acceptance.
4. DEPTH=4, out_ready=0: push 4 legal words -> in_ready=0 and the 5th is held. Assert out_ready for one cycle -> first word popped, 5th accepted next cycle, order preserved.
5. in_mnem=25 accepted -> no FIFO push, illegal high one cycle, err_cnt=1. Then 260 illegal words -> err_cnt=255.
6. BR_NOPS=3, assert rst_n low mid-PAD with 2 words queued -> out_valid=0, err_cnt=0, state ACCEPT. A legal word after release emerges alone.
